// File: rtl/fifo_word_packer.sv
// Packs LANES consecutive entries from a 1-cycle-latency FIFO into one little-endian word.
// Full words leave LANES+2 cycles after the first read. A partial word is flushed after TIMEOUT idle cycles. The held word stalls all reads until it is accepted.
module fifo_word_packer #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       fifo_dout,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic [LANES*WIDTH-1:0] m_data,
    output logic [$clog2(LANES):0] m_bytes,
    output logic                   m_valid,
    input  logic                   m_ready
);

    localparam int CW = $clog2(LANES) + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   pend;
    logic [CW-1:0]          lane_cnt;
    logic [IW-1:0]          idle_cnt;
    logic [LANES*WIDTH-1:0] lanes;
    logic [CW:0]            inflight;
    logic                   last_lane;
    logic                   idle_inc;
    logic                   timeout;
    logic                   accept;

    // Lanes already filled plus the read still in flight bound how many more reads fit.
    assign inflight  = {1'b0, lane_cnt} + {{CW{1'b0}}, pend};
    assign last_lane = pend && (lane_cnt == CW'(LANES - 1));
    assign idle_inc  = (state == COLLECT) && (lane_cnt != '0) && !pend && fifo_empty;
    assign timeout   = idle_inc && (idle_cnt == IW'(TIMEOUT - 1));
    assign accept    = (state == EMIT) && m_ready;

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            COLLECT: begin
                fifo_rd_en = !rst && !fifo_empty && (inflight < (CW+1)'(LANES));
                if (last_lane || timeout) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            lane_cnt <= '0;
            idle_cnt <= '0;
            lanes    <= '0;
        end else begin
            pend <= fifo_rd_en;
            if (accept) begin
                lanes    <= '0;
                lane_cnt <= '0;
                idle_cnt <= '0;
            end else begin
                if (pend) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (lane_cnt == CW'(k)) begin
                            lanes[k*WIDTH +: WIDTH] <= fifo_dout;
                        end
                    end
                    lane_cnt <= lane_cnt + CW'(1);
                end
                if (pend || (lane_cnt == '0)) begin
                    idle_cnt <= '0;
                end else if (idle_inc) begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

    // Unfilled lanes stay zero because every lane is cleared on acceptance and reset.
    assign m_valid = (state == EMIT);
    assign m_data  = lanes;
    assign m_bytes = lane_cnt;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: byte-stream scoreboard with an upstream FIFO model,
// directed scenarios with literal words, and a randomized traffic phase.
module tb_fifo_word_packer;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int T  = 8;
    localparam int DW = W * L;
    localparam int BW = $clog2(L) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic [BW-1:0] m_bytes;
    logic          m_valid;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_word_packer #(.WIDTH(W), .LANES(L), .TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_bytes    (m_bytes),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  fq[$];
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] wdata[$];
    int            wbytes[$];
    int            wcyc[$];
    int            cyc = 0;
    int            rd_pulses = 0;
    int            empty_run = 0;
    bit            prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [BW-1:0] prev_bytes = '0;
    logic          rd_s = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(fifo_rd_en && (fifo_empty || m_valid)))
            else $error("FAIL rd_en_guard_assert: rd_en=%b empty=%b valid=%b",
                        fifo_rd_en, fifo_empty, m_valid);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle checks against the stream model: byte order, zero fill, hold while
    // stalled, read guard, and the exact idle gap that must precede a partial word.
    task automatic monitor();
        logic [W-1:0] e;
        if (rst) return;
        chk("rd_en_guard", 64'(fifo_rd_en && (fifo_empty || m_valid)), 64'd0);
        if (fifo_rd_en) rd_pulses++;
        if (m_valid) begin
            chk("bytes_range", 64'((m_bytes != 0) && (m_bytes <= L)), 64'd1);
            if (prev_valid) begin
                chk("hold_data_stable", 64'(m_data), 64'(prev_data));
                chk("hold_bytes_stable", 64'(m_bytes), 64'(prev_bytes));
            end else if (m_bytes < L) begin
                chk("timeout_gap", 64'(empty_run), 64'(T + 1));
            end
            if (m_ready) begin
                for (int k = 0; k < L; k++) begin
                    if (k < int'(m_bytes)) begin
                        chk("stream_has_byte", 64'(exp_q.size() > 0), 64'd1);
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                        chk("lane_data", 64'(m_data[k*W +: W]), 64'(e));
                    end else begin
                        chk("lane_zero_fill", 64'(m_data[k*W +: W]), 64'd0);
                    end
                end
                wdata.push_back(m_data);
                wbytes.push_back(int'(m_bytes));
                wcyc.push_back(cyc);
            end
        end else if (fifo_empty) begin
            empty_run++;
        end
        if (!fifo_empty) empty_run = 0;
        prev_valid = m_valid && !m_ready;
        prev_data  = m_data;
        prev_bytes = m_bytes;
    endtask

    // One clock: check at the falling edge, then model the synchronous FIFO read.
    task automatic step();
        @(negedge clk);
        monitor();
        rd_s = fifo_rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_s && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic push(input logic [W-1:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic reset_on();
        rst = 1'b1;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_bytes", 64'(m_bytes), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        fq.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        prev_valid = 1'b0;
        empty_run  = 0;
    endtask

    task automatic reset_off();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            step();
            n++;
        end
        chk({name, "_valid"}, 64'(m_valid), 64'd1);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || m_valid) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int viol;
        int base;
        int r0;
        int n;
        int ph;
        int p;

        #2;
        reset_on();
        reset_off();

        // Empty FIFO from reset: nothing may be read or emitted.
        m_ready = 1'b1;
        viol = 0;
        repeat (50) begin
            step();
            if (fifo_rd_en || m_valid) viol++;
        end
        chk("empty_quiet", 64'(viol), 64'd0);

        // Preloaded 0x01..0x08 with the sink always ready.
        reset_on();
        for (int i = 1; i <= 8; i++) push(W'(i));
        reset_off();
        base = wdata.size();
        r0 = rd_pulses;
        n = 0;
        while (wdata.size() < base + 2 && n < 60) begin
            step();
            n++;
        end
        repeat (4) step();
        chk("seq_word_count", 64'(wdata.size() - base), 64'd2);
        if (wdata.size() >= base + 2) begin
            chk("seq_word0", 64'(wdata[base]), 64'h04030201);
            chk("seq_bytes0", 64'(wbytes[base]), 64'd4);
            chk("seq_word1", 64'(wdata[base+1]), 64'h08070605);
            chk("seq_bytes1", 64'(wbytes[base+1]), 64'd4);
            chk("seq_period", 64'(wcyc[base+1] - wcyc[base]), 64'(L + 2));
        end
        chk("seq_rd_pulses", 64'(rd_pulses - r0), 64'd8);

        // Sink stalled for 10 cycles while more data waits upstream.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(W'(8'hC0 + i));
        wait_valid("hold", 30);
        push(8'hD0);
        repeat (10) begin
            step();
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_rd_en", 64'(fifo_rd_en), 64'd0);
            chk("hold_data", 64'(m_data), 64'hC3C2C1C0);
            chk("hold_bytes", 64'(m_bytes), 64'd4);
        end
        m_ready = 1'b1;
        drain("hold", 100);

        // Three bytes then silence: partial word after the idle timeout.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_valid("timeout", 40);
        chk("timeout_data", 64'(m_data), 64'h00332211);
        chk("timeout_bytes", 64'(m_bytes), 64'd3);
        step();

        // Reset with two bytes captured; the partial word must vanish.
        push(8'h55);
        push(8'h66);
        repeat (4) step();
        reset_on();
        reset_off();
        for (int i = 0; i < 4; i++) push(W'(8'hA0 + i));
        wait_valid("rst_resume", 30);
        chk("rst_resume_data", 64'(m_data), 64'hA3A2A1A0);
        chk("rst_resume_bytes", 64'(m_bytes), 64'd4);
        step();

        // Random traffic: bursts, trickles and gaps, random sink stalls, one mid-stream reset.
        for (int i = 0; i < 2400; i++) begin
            step();
            if (i == 1200) begin
                reset_on();
                reset_off();
            end
            m_ready = ($urandom_range(0, 3) != 0);
            ph = (i / 150) % 3;
            p  = (ph == 0) ? 70 : ((ph == 1) ? 8 : 0);
            if (int'($urandom_range(0, 99)) < p) push(W'($urandom_range(0, 255)));
        end
        m_ready = 1'b1;
        drain("rand", 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, FIFO data width in bits.
REQ-002 SHALL have parameter LANES, default 4, number of FIFO entries packed per output word.
REQ-003 SHALL have parameter TIMEOUT, default 8, idle cycles before a partial word is flushed.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port fifo_dout  input  WIDTH  read data from upstream synchronous FIFO.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_rd_en  output  1  read request to upstream FIFO.
REQ-009 SHALL have port m_data  output  LANES*WIDTH  packed output word.
REQ-010 SHALL have port m_bytes  output  $clog2(LANES)+1  number of valid lanes in m_data.
REQ-011 SHALL have port m_valid  output  1  output word valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts word when high with m_valid.

Function
REQ-013 SHALL treat the upstream FIFO as having 1-cycle read latency: fifo_dout is valid the cycle after the edge on which fifo_rd_en=1 was sampled.
REQ-014 SHALL keep a registered pend flag, set to fifo_rd_en each edge; when pend=1, fifo_dout is captured into lane lane_cnt and lane_cnt increments.
REQ-015 SHALL pack little-endian: first captured entry in m_data[WIDTH-1:0], lane k in bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-016 SHALL implement two states, COLLECT and EMIT.
REQ-017 SHALL drive fifo_rd_en combinationally = (state==COLLECT) && !fifo_empty && (lane_cnt + pend < LANES).
REQ-018 SHALL never assert fifo_rd_en while fifo_empty=1 or in EMIT.
REQ-019 SHALL go COLLECT->EMIT on the edge where the capture fills lane LANES-1; m_bytes=LANES.
REQ-020 SHALL keep an idle counter, cleared on every capture and whenever lane_cnt=0, incremented each COLLECT cycle with lane_cnt>0, pend=0, fifo_empty=1.
REQ-021 SHALL go COLLECT->EMIT when the idle counter reaches TIMEOUT, with m_bytes=lane_cnt and unfilled lanes driven 0.
REQ-022 SHALL assert m_valid only in EMIT, holding m_data and m_bytes stable until m_ready=1.
REQ-023 SHALL, on an edge with m_valid=1 and m_ready=1, clear all lanes, lane_cnt and idle counter and return to COLLECT; next fifo_rd_en may assert in the following cycle.
REQ-024 SHALL sustain, with a non-empty FIFO and m_ready=1, one full word per LANES+2 cycles (LANES reads, one latency cycle, one EMIT cycle).
REQ-025 SHALL NOT emit a word with m_bytes=0.

Reset
REQ-026 SHALL, on rst=1, immediately force state=COLLECT, lane_cnt=0, pend=0, idle counter=0, lanes=0, m_valid=0, m_bytes=0, m_data=0, fifo_rd_en=0.
REQ-027 SHALL, on reset mid-word or with a read outstanding, discard the partial word and ignore the in-flight fifo_dout.
REQ-028 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-029 SHALL verify: FIFO preloaded 0x01..0x08, m_ready=1 -> words 0x04030201 then 0x08070605, m_bytes=4 each, exactly 8 fifo_rd_en pulses.
REQ-030 SHALL verify: m_ready held 0 for 10 cycles during EMIT -> m_data/m_bytes stable, m_valid=1, fifo_rd_en=0 throughout.
REQ-031 SHALL verify: 0x11,0x22,0x33 then FIFO empty -> after 8 idle cycles m_data=0x00332211, m_bytes=3.
REQ-032 SHALL verify: FIFO empty from reset for 50 cycles -> fifo_rd_en=0, m_valid=0 always.
REQ-033 SHALL verify: rst pulsed after 2 bytes captured -> outputs zero immediately; next 4 bytes 0xA0..0xA3 yield 0xA3A2A1A0, m_bytes=4.
REQ-034 SHALL verify by assertion throughout all tests: fifo_rd_en never 1 while fifo_empty=1 or m_valid=1.
